wb_capture_fifo: RTL and testbench

Sink for the pipeline's write-back stream. It captures each committed write-back (destination register plus the value driven on the WB mux output) into a FIFO. A bench or debug host drains the FIFO through a show-ahead read port. It also keeps sticky overflow status, a drop counter and an accept counter, so lost results are always visible.

---
 rtl/wb_capture_fifo.sv | 113 +++++++++++
 tb/tb_wb_capture_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_capture_fifo.sv
// Write-back capture FIFO: stores {reg, data} commits behind a show-ahead read port, with
// sticky overflow, a saturating drop counter and a wrapping accept counter.
// Define WB_CAPTURE_FILTER_R0_EN to ignore commits that target register 0.
module wb_capture_fifo #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_W      = 5,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wb_valid,
    input  logic [REG_W-1:0]      wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [REG_W-1:0]      rd_reg,
    output logic [DATA_W-1:0]     rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    output logic [31:0]           accept_count
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned ENT_W = REG_W + DATA_W;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [LVL_W-1:0]      LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(DEPTH);

    logic [ENT_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  overflow_q;
    logic [15:0]           drop_q;
    logic [31:0]           accept_q;

    logic take;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
`ifdef WB_CAPTURE_FILTER_R0_EN
        // Register 0 is hard-wired, so its write-back carries nothing worth keeping.
        take = wb_valid && (wb_reg != '0);
`else
        take = wb_valid;
`endif
        is_full = (level_q == LVL_FULL);
        pop     = rd_en && (level_q != '0);
        push    = take && (!is_full || pop);
        drop    = take && is_full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            accept_q   <= '0;
        end else if (clr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            accept_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                accept_q <= accept_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_ONE;
            end else if (pop && !push) begin
                level_q <= level_q - LVL_ONE;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end
        end
    end

    // Storage needs no reset; validity is tracked entirely by level_q.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q] <= {wb_reg, wb_data};
        end
    end

    assign rd_valid          = (level_q != '0);
    assign {rd_reg, rd_data} = mem_q[rd_ptr_q];
    assign level             = level_q;
    assign full              = is_full;
    assign overflow          = overflow_q;
    assign drop_count        = drop_q;
    assign accept_count      = accept_q;

endmodule

// File: tb/tb_wb_capture_fifo.sv
// Directed self-checking bench for wb_capture_fifo; honours WB_CAPTURE_FILTER_R0_EN when defined.
module tb_wb_capture_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        rd_en;
    logic        rd_valid;
    logic [4:0]  rd_reg;
    logic [31:0] rd_data;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic [15:0] drop_count;
    logic [31:0] accept_count;

    int checks   = 0;
    int failures = 0;

    wb_capture_fifo #(
        .DATA_W     (32),
        .REG_W      (5),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_reg       (rd_reg),
        .rd_data      (rd_data),
        .level        (level),
        .full         (full),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d, input logic pop_too);
        wb_valid = 1'b1;
        wb_reg   = r;
        wb_data  = d;
        rd_en    = pop_too;
        step();
        wb_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        wb_valid = 1'b0;
        wb_reg   = '0;
        wb_data  = '0;
        rd_en    = 1'b0;
        step();
        chk("rst_level", 64'(level), 0);
        chk("rst_valid", 64'(rd_valid), 0);
        chk("rst_full", 64'(full), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_drop", 64'(drop_count), 0);
        chk("rst_acc", 64'(accept_count), 0);
        rst_n = 1'b1;
        step();

        // Single commit, 1-cycle write-to-read latency
        push(5'd3, 32'h0000_00A5, 1'b0);
        chk("t1_valid", 64'(rd_valid), 1);
        chk("t1_reg", 64'(rd_reg), 3);
        chk("t1_data", 64'(rd_data), 64'h A5);
        chk("t1_level", 64'(level), 1);
        chk("t1_acc", 64'(accept_count), 1);
        pop_one();
        chk("t1_pop_valid", 64'(rd_valid), 0);
        chk("t1_pop_level", 64'(level), 0);
        pop_one();
        chk("t1_empty_pop_level", 64'(level), 0);

        // Fill and overflow: 18 commits, last two dropped
        for (int i = 0; i < 18; i++) begin
            push(5'((i % 8) + 1), 32'(i), 1'b0);
        end
        chk("t2_full", 64'(full), 1);
        chk("t2_level", 64'(level), 16);
        chk("t2_ovf", 64'(overflow), 1);
        chk("t2_drop", 64'(drop_count), 2);
        chk("t2_acc", 64'(accept_count), 17);
        chk("t2_head", 64'(rd_data), 0);

        // Full with simultaneous pop: accepted, no drop
        push(5'd9, 32'h55, 1'b1);
        chk("t3_level", 64'(level), 16);
        chk("t3_drop", 64'(drop_count), 2);
        chk("t3_acc", 64'(accept_count), 18);
        for (int k = 1; k < 16; k++) begin
            chk("t3_drain_valid", 64'(rd_valid), 1);
            chk("t3_drain_data", 64'(rd_data), 64'(k));
            chk("t3_drain_reg", 64'(rd_reg), 64'((k % 8) + 1));
            pop_one();
            chk("t3_drain_full", 64'(full), 0);
        end
        chk("t3_last_data", 64'(rd_data), 64'h55);
        chk("t3_last_reg", 64'(rd_reg), 9);
        pop_one();
        chk("t3_empty", 64'(rd_valid), 0);
        chk("t3_ovf_sticky", 64'(overflow), 1);

        // Flush counters before the wrap test
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_acc", 64'(accept_count), 0);
        chk("clr_ovf", 64'(overflow), 0);

        // Wrap-around: 40 push/pop pairs
        for (int c = 0; c < 40; c++) begin
            push(5'd4, 32'(c), 1'b0);
            chk("t4_level", 64'(level), 1);
            chk("t4_data", 64'(rd_data), 64'(c));
            pop_one();
            chk("t4_level0", 64'(level), 0);
        end
        chk("t4_acc", 64'(accept_count), 40);

        // Push and pop together at level 1: new entry becomes head
        push(5'd6, 32'd100, 1'b0);
        push(5'd7, 32'd101, 1'b1);
        chk("t4_pp_valid", 64'(rd_valid), 1);
        chk("t4_pp_level", 64'(level), 1);
        chk("t4_pp_data", 64'(rd_data), 101);
        chk("t4_pp_acc", 64'(accept_count), 42);
        pop_one();

        // Clear at level 5 with overflow set, commit in the same cycle
        for (int i = 0; i < 17; i++) begin
            push(5'd2, 32'(i), 1'b0);
        end
        for (int i = 0; i < 11; i++) begin
            pop_one();
        end
        chk("t5_pre_level", 64'(level), 5);
        chk("t5_pre_ovf", 64'(overflow), 1);
        clr      = 1'b1;
        wb_valid = 1'b1;
        wb_reg   = 5'd8;
        wb_data  = 32'hBEEF;
        step();
        clr      = 1'b0;
        wb_valid = 1'b0;
        chk("t5_level", 64'(level), 0);
        chk("t5_valid", 64'(rd_valid), 0);
        chk("t5_ovf", 64'(overflow), 0);
        chk("t5_drop", 64'(drop_count), 0);
        chk("t5_acc", 64'(accept_count), 0);
        step();
        chk("t5_not_stored", 64'(level), 0);

        // Asynchronous reset mid-cycle
        push(5'd1, 32'd1, 1'b0);
        push(5'd1, 32'd2, 1'b0);
        push(5'd1, 32'd3, 1'b0);
        chk("t5r_pre_level", 64'(level), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5r_level", 64'(level), 0);
        chk("t5r_valid", 64'(rd_valid), 0);
        chk("t5r_acc", 64'(accept_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register-0 filter
        push(5'd0, 32'hDEAD, 1'b0);
        push(5'd7, 32'h1234, 1'b0);
`ifdef WB_CAPTURE_FILTER_R0_EN
        chk("t6_acc", 64'(accept_count), 1);
        chk("t6_level", 64'(level), 1);
        chk("t6_reg", 64'(rd_reg), 7);
        chk("t6_data", 64'(rd_data), 64'h1234);
`else
        chk("t6_acc", 64'(accept_count), 2);
        chk("t6_level", 64'(level), 2);
        chk("t6_reg0", 64'(rd_reg), 0);
        chk("t6_data0", 64'(rd_data), 64'h DEAD);
        pop_one();
        chk("t6_reg1", 64'(rd_reg), 7);
        chk("t6_data1", 64'(rd_data), 64'h1234);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
